// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the timing generator drives it and the pixel pipeline and pins consume it.
interface vga_timing_gen_if;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_start;
    logic       frame_start;

    modport master (output hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start);
    modport slave  (input  hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters with per-axis phase FSMs and
// registered sync/enable/coordinate/strobe outputs, one dot behind the counters.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic             dotclock,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 ||
            H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_geom
            $error("vga_timing_gen: illegal raster geometry");
        end
    endgenerate

    // Phase boundaries, expressed as the counter value that opens each phase.
    localparam logic [9:0] H_FP_AT = 10'(H_ACTIVE);
    localparam logic [9:0] H_SY_AT = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_AT = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_FP_AT = 10'(V_ACTIVE);
    localparam logic [9:0] V_SY_AT = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_AT = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_e;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       line_start;
        logic       frame_start;
    } tmg_t;

    localparam tmg_t TMG_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL, de: 1'b0,
                                  x: '0, y: '0, line_start: 1'b0, frame_start: 1'b0};

    logic [9:0] h_cnt, v_cnt;
    logic [9:0] h_nxt, v_nxt;
    logic       h_wrap;
    phase_e     h_state, v_state;
    tmg_t       tmg_q;

    // The state is advanced from the counter's next value so state and counter
    // always describe the same position.
    function automatic phase_e phase_step(phase_e cur, logic [9:0] nxt,
                                          logic [9:0] fp_at, logic [9:0] sy_at,
                                          logic [9:0] bp_at);
        phase_e ph;
        ph = cur;
        if (nxt == fp_at)      ph = PH_FRONT;
        else if (nxt == sy_at) ph = PH_SYNC;
        else if (nxt == bp_at) ph = PH_BACK;
        else if (nxt == '0)    ph = PH_ACTIVE;
        return ph;
    endfunction

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_nxt  = h_wrap ? '0 : h_cnt + 10'd1;
        v_nxt  = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end

    always_ff @(posedge dotclock or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            h_state <= PH_ACTIVE;
            v_state <= PH_ACTIVE;
            tmg_q   <= TMG_IDLE;
        end else begin
            tmg_q.hsync       <= (h_state == PH_SYNC) ? HS_POL : ~HS_POL;
            tmg_q.vsync       <= (v_state == PH_SYNC) ? VS_POL : ~VS_POL;
            tmg_q.de          <= (h_state == PH_ACTIVE) && (v_state == PH_ACTIVE);
            tmg_q.x           <= h_cnt;
            tmg_q.y           <= v_cnt;
            tmg_q.line_start  <= (h_cnt == '0);
            tmg_q.frame_start <= (h_cnt == '0) && (v_cnt == '0);

            h_cnt   <= h_nxt;
            h_state <= phase_step(h_state, h_nxt, H_FP_AT, H_SY_AT, H_BP_AT);
            if (h_wrap) begin
                v_cnt   <= v_nxt;
                v_state <= phase_step(v_state, v_nxt, V_FP_AT, V_SY_AT, V_BP_AT);
            end
        end
    end

    assign vga.hsync       = tmg_q.hsync;
    assign vga.vsync       = tmg_q.vsync;
    assign vga.de          = tmg_q.de;
    assign vga.pixel_x     = tmg_q.x;
    assign vga.pixel_y     = tmg_q.y;
    assign vga.line_start  = tmg_q.line_start;
    assign vga.frame_start = tmg_q.frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: four geometries share one clock and reset,
// expected outputs come from a closed-form position model.
module tb_vga_timing_gen;
    logic dotclock = 1'b0;
    logic rst_n    = 1'b0;
    always #5 dotclock = ~dotclock;

    vga_timing_gen_if if_def();
    vga_timing_gen_if if_pol();
    vga_timing_gen_if if_mid();
    vga_timing_gen_if if_wrp();

    vga_timing_gen u_def (.dotclock(dotclock), .rst_n(rst_n), .vga(if_def));
    vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1))
        u_pol (.dotclock(dotclock), .rst_n(rst_n), .vga(if_pol));
    vga_timing_gen #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3))
        u_mid (.dotclock(dotclock), .rst_n(rst_n), .vga(if_mid));
    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1))
        u_wrp (.dotclock(dotclock), .rst_n(rst_n), .vga(if_wrp));

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } obs_t;
    typedef obs_t [3:0] obs4_t;
    typedef struct { int ha, hf, hs, hb, va, vf, vs, vb; bit hp, vp; } geom_t;

    geom_t g [4];
    obs4_t sb_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    k       = 0;
    bit    seg2    = 1'b0;
    int    n_seg2  = 0;
    int    def_hs_cnt = 0, def_de_cnt = 0, def_fs_cnt = 0, pol_hs_cnt = 0;
    int    mid_ls_cnt = 0, mid_vs_cnt = 0, mid_de_cnt = 0, mid_fs_cnt = 0;
    int    wrp_fwrap_cnt = 0;
    logic [9:0] wrp_px = '0, wrp_py = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic obs_t model(input geom_t p, input int kk, input bit idle);
        obs_t o;
        int ht, vt, h, v;
        o    = '0;
        o.hs = ~p.hp;
        o.vs = ~p.vp;
        if (idle) return o;
        ht = p.ha + p.hf + p.hs + p.hb;
        vt = p.va + p.vf + p.vs + p.vb;
        h  = kk % ht;
        v  = (kk / ht) % vt;
        if (h >= p.ha + p.hf && h < p.ha + p.hf + p.hs) o.hs = p.hp;
        if (v >= p.va + p.vf && v < p.va + p.vf + p.vs) o.vs = p.vp;
        o.de = (h < p.ha) && (v < p.va);
        o.x  = 10'(h);
        o.y  = 10'(v);
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic int ph(input int c, input int a, input int f, input int s);
        if (c < a)         return 0;
        if (c < a + f)     return 1;
        if (c < a + f + s) return 2;
        return 3;
    endfunction

    function automatic obs4_t grab();
        obs4_t o;
        o[0] = {if_def.hsync, if_def.vsync, if_def.de, if_def.pixel_x, if_def.pixel_y, if_def.line_start, if_def.frame_start};
        o[1] = {if_pol.hsync, if_pol.vsync, if_pol.de, if_pol.pixel_x, if_pol.pixel_y, if_pol.line_start, if_pol.frame_start};
        o[2] = {if_mid.hsync, if_mid.vsync, if_mid.de, if_mid.pixel_x, if_mid.pixel_y, if_mid.line_start, if_mid.frame_start};
        o[3] = {if_wrp.hsync, if_wrp.vsync, if_wrp.de, if_wrp.pixel_x, if_wrp.pixel_y, if_wrp.line_start, if_wrp.frame_start};
        return o;
    endfunction

    task automatic push_exp(input bit idle);
        obs4_t e;
        for (int i = 0; i < 4; i++) e[i] = model(g[i], k, idle);
        sb_q.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        obs4_t e, o;
        o = grab();
        e = sb_q.pop_front();
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_d%0d_k%0d", tag, i, k), {7'd0, o[i]}, {7'd0, e[i]});
    endtask

    // Phase FSMs must match the counter range they decode.
    task automatic fsm_chk();
        chk("def_hfsm", int'(u_def.h_state), ph(int'(u_def.h_cnt), 640, 16, 96));
        chk("def_vfsm", int'(u_def.v_state), ph(int'(u_def.v_cnt), 480, 10, 2));
        chk("mid_vfsm", int'(u_mid.v_state), ph(int'(u_mid.v_cnt), 6, 2, 2));
        chk("wrp_hfsm", int'(u_wrp.h_state), ph(int'(u_wrp.h_cnt), 4, 1, 2));
        chk("wrp_vfsm", int'(u_wrp.v_state), ph(int'(u_wrp.v_cnt), 3, 1, 1));
    endtask

    task automatic stats();
        if (k < 800) begin
            if (if_def.hsync == 1'b0) def_hs_cnt++;
            if (if_def.de) def_de_cnt++;
            if (if_pol.hsync == 1'b1) pol_hs_cnt++;
        end
        if (k == 800) chk("def_ls_n801", {31'd0, if_def.line_start}, 32'd1);
        if (if_def.frame_start) def_fs_cnt++;
        if (k < 10400) begin
            if (if_mid.line_start) mid_ls_cnt++;
            if (if_mid.vsync == 1'b0) mid_vs_cnt++;
            if (if_mid.de) mid_de_cnt++;
        end
        if (if_mid.frame_start) mid_fs_cnt++;
        if (k > 0 && if_wrp.pixel_y != wrp_py) begin
            chk("wrp_y_step_x", {12'd0, wrp_px, if_wrp.pixel_x}, {12'd0, 10'd7, 10'd0});
            if (wrp_py == 10'd5 && if_wrp.pixel_y == 10'd0) wrp_fwrap_cnt++;
        end
        wrp_px = if_wrp.pixel_x;
        wrp_py = if_wrp.pixel_y;
    endtask

    task automatic run_edge(input bit idle);
        push_exp(idle);
        @(posedge dotclock);
        @(negedge dotclock);
        pop_cmp(idle ? "rst" : "run");
        fsm_chk();
        if (!idle) begin
            if (seg2) begin
                stats();
                n_seg2++;
            end
            k++;
        end
    endtask

    initial begin
        g[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        g[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1};
        g[2] = '{640, 16, 96, 48, 6, 2, 2, 3, 1'b0, 1'b0};
        g[3] = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0};

        rst_n = 1'b0;
        repeat (5) run_edge(1'b1);
        rst_n = 1'b1;
        k = 0;
        // Run up to the dot that presents (300,2) on the default geometry.
        repeat (2 * 800 + 300 + 1) run_edge(1'b0);

        rst_n = 1'b0;
        #1;
        push_exp(1'b1);
        pop_cmp("rst_async");
        run_edge(1'b1);
        rst_n = 1'b1;
        k = 0;
        seg2 = 1'b1;
        repeat (2 * 10400 + 5) run_edge(1'b0);

        chk("def_hs_dots_line0", def_hs_cnt, 96);
        chk("def_de_dots_line0", def_de_cnt, 640);
        chk("def_fs_count", def_fs_cnt, 1);
        chk("pol_hs_dots_line0", pol_hs_cnt, 96);
        chk("mid_ls_per_frame", mid_ls_cnt, 13);
        chk("mid_vs_dots_frame", mid_vs_cnt, 1600);
        chk("mid_de_dots_frame", mid_de_cnt, 3840);
        chk("mid_fs_count", mid_fs_cnt, 3);
        chk("wrp_frame_wraps", wrp_fwrap_cnt, (n_seg2 - 1) / 48);
        chk("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
